// File: rtl/dsram_axi_bridge_if.sv
`timescale 1ns/1ps
// Bundle between the core's data-SRAM port, the bridge and the AXI4-Lite slave.
// The "master" view is the bridge; the "slave" view is everything on the other side.
interface dsram_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Core request / response side
    logic                  req_en;
    logic [DATA_W/8-1:0]   req_wen;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W-1:0]     req_rdata;
    logic                  stallreq;
    logic                  resp_err;

    // AXI4-Lite read channels
    logic [ADDR_W-1:0]     araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    // AXI4-Lite write channels
    logic [ADDR_W-1:0]     awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        input  req_en, req_wen, req_addr, req_wdata,
        output req_rdata, stallreq, resp_err,
        output araddr, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        output req_en, req_wen, req_addr, req_wdata,
        input  req_rdata, stallreq, resp_err,
        input  araddr, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/dsram_axi_bridge.sv
`timescale 1ns/1ps
// Data-side bridge: one EX request becomes exactly one AXI4-Lite read or write, with the
// pipeline stalled until the response returns. Single outstanding transaction.
module dsram_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    dsram_axi_bridge_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRB_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_addr;
    logic [STRB_W-1:0]   r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_aw_done;
    logic                r_w_done;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_resp_err;

    logic                w_capture;
    logic                w_r_fire;
    logic                w_aw_fire;
    logic                w_w_fire;
    logic                w_wr_done;
    logic                w_b_fire;
    logic [ADDR_W-1:0]   w_addr_aligned;

    assign w_addr_aligned = r_addr & ALIGN_MASK;

    // Payload fields only change on a new capture, so they stay stable while any valid is high.
    assign bus.araddr    = w_addr_aligned;
    assign bus.awaddr    = w_addr_aligned;
    assign bus.wdata     = r_wdata;
    assign bus.wstrb     = r_wen;
    assign bus.req_rdata = r_rdata;
    assign bus.resp_err  = r_resp_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Valids derive from state and done flags only, never from the matching ready.
    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_r_fire     = 1'b0;
        w_aw_fire    = 1'b0;
        w_w_fire     = 1'b0;
        w_wr_done    = 1'b0;
        w_b_fire     = 1'b0;
        bus.arvalid  = 1'b0;
        bus.rready   = 1'b0;
        bus.awvalid  = 1'b0;
        bus.wvalid   = 1'b0;
        bus.bready   = 1'b0;
        bus.stallreq = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.stallreq = bus.req_en;
                if (bus.req_en) begin
                    w_capture   = 1'b1;
                    w_state_nxt = (bus.req_wen == '0) ? S_RD_ADDR : S_WR_REQ;
                end
            end
            S_RD_ADDR: begin
                bus.stallreq = 1'b1;
                bus.arvalid  = 1'b1;
                if (bus.arready) begin
                    w_state_nxt = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                bus.stallreq = 1'b1;
                bus.rready   = 1'b1;
                w_r_fire     = bus.rvalid;
                if (bus.rvalid) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_WR_REQ: begin
                bus.stallreq = 1'b1;
                bus.awvalid  = !r_aw_done;
                bus.wvalid   = !r_w_done;
                w_aw_fire    = !r_aw_done && bus.awready;
                w_w_fire     = !r_w_done && bus.wready;
                w_wr_done    = (r_aw_done || w_aw_fire) && (r_w_done || w_w_fire);
                if (w_wr_done) begin
                    w_state_nxt = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                bus.stallreq = 1'b1;
                bus.bready   = 1'b1;
                w_b_fire     = bus.bvalid;
                if (bus.bvalid) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request payload is only meaningful after a capture, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (w_capture) begin
            r_addr  <= bus.req_addr;
            r_wen   <= bus.req_wen;
            r_wdata <= bus.req_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_rdata    <= '0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_r_fire) begin
                r_rdata    <= bus.rdata;
                r_resp_err <= (bus.rresp != 2'b00);
            end else if (w_b_fire) begin
                r_resp_err <= (bus.bresp != 2'b00);
            end
            if (w_wr_done) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_fire) begin
                    r_aw_done <= 1'b1;
                end
                if (w_w_fire) begin
                    r_w_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dsram_axi_bridge.sv
`timescale 1ns/1ps
// Bench for dsram_axi_bridge: AXI4-Lite slave with programmable waits/responses plus a
// word-level memory model predicting latency, load data, error flag and bus traffic.
module tb_dsram_axi_bridge;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dsram_axi_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
    dsram_axi_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Slave configuration (written by the test sequence only)
    int cfg_ar_wait = 0, cfg_r_wait = 0, cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0;
    logic [1:0] cfg_rresp = 2'b00, cfg_bresp = 2'b00;

    // Slave internals and bus monitors (written by the slave process only)
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit r_pend, b_pend, aw_got, w_got;
    bit ar_hold, aw_hold, w_hold;
    logic [31:0] ar_prev, aw_prev, w_prev, r_addr_lat;
    logic [3:0]  ws_prev;
    int n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0;
    int aw_vcyc = 0, w_vcyc = 0, stab_viol = 0;
    logic [31:0] mon_araddr, mon_awaddr, mon_wdata;
    logic [3:0]  mon_wstrb;
    logic [31:0] smem [logic [31:0]];

    // Reference model state
    logic [31:0] mmem [logic [31:0]];
    logic [31:0] exp_rdata = 32'h0;

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
            bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
            r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            ar_hold = 0; aw_hold = 0; w_hold = 0;
        end else begin
            if (ar_hold && (bus.arvalid !== 1'b1 || bus.araddr !== ar_prev)) stab_viol++;
            if (aw_hold && (bus.awvalid !== 1'b1 || bus.awaddr !== aw_prev)) stab_viol++;
            if (w_hold && (bus.wvalid !== 1'b1 || bus.wdata !== w_prev || bus.wstrb !== ws_prev))
                stab_viol++;
            ar_hold = bus.arvalid && !bus.arready; ar_prev = bus.araddr;
            aw_hold = bus.awvalid && !bus.awready; aw_prev = bus.awaddr;
            w_hold  = bus.wvalid && !bus.wready;   w_prev = bus.wdata; ws_prev = bus.wstrb;
            if (bus.awvalid) aw_vcyc++;
            if (bus.wvalid) w_vcyc++;
            if (bus.arvalid && bus.arready) begin
                n_ar++; mon_araddr = bus.araddr; r_addr_lat = bus.araddr; r_pend = 1; r_cnt = 0;
            end
            if (bus.rvalid && bus.rready) begin n_r++; r_pend = 0; end
            if (bus.awvalid && bus.awready) begin n_aw++; mon_awaddr = bus.awaddr; aw_got = 1; end
            if (bus.wvalid && bus.wready) begin
                n_w++; mon_wdata = bus.wdata; mon_wstrb = bus.wstrb; w_got = 1;
            end
            if (bus.bvalid && bus.bready) begin n_b++; b_pend = 0; end
            if (aw_got && w_got) begin
                logic [31:0] cur;
                cur = smem.exists(mon_awaddr) ? smem[mon_awaddr] : 32'h0;
                for (int k = 0; k < 4; k++)
                    if (mon_wstrb[k]) cur[8*k +: 8] = mon_wdata[8*k +: 8];
                smem[mon_awaddr] = cur;
                aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
            end
            #1;
            if (bus.arvalid) begin
                if (ar_cnt >= cfg_ar_wait) bus.arready = 1'b1;
                else begin bus.arready = 1'b0; ar_cnt++; end
            end else begin bus.arready = 1'b0; ar_cnt = 0; end
            if (bus.awvalid) begin
                if (aw_cnt >= cfg_aw_wait) bus.awready = 1'b1;
                else begin bus.awready = 1'b0; aw_cnt++; end
            end else begin bus.awready = 1'b0; aw_cnt = 0; end
            if (bus.wvalid) begin
                if (w_cnt >= cfg_w_wait) bus.wready = 1'b1;
                else begin bus.wready = 1'b0; w_cnt++; end
            end else begin bus.wready = 1'b0; w_cnt = 0; end
            if (r_pend && r_cnt >= cfg_r_wait) begin
                bus.rvalid = 1'b1; bus.rresp = cfg_rresp;
                bus.rdata = smem.exists(r_addr_lat) ? smem[r_addr_lat] : 32'h0;
            end else begin
                bus.rvalid = 1'b0;
                if (r_pend) r_cnt++;
            end
            if (b_pend && b_cnt >= cfg_b_wait) begin
                bus.bvalid = 1'b1; bus.bresp = cfg_bresp;
            end else begin
                bus.bvalid = 1'b0;
                if (b_pend) b_cnt++;
            end
        end
    end

    // Issue one request; returns the cycle index of the first non-stalled cycle (DONE).
    task automatic drive_txn(input logic [31:0] addr, input logic [3:0] wen,
                             input logic [31:0] wdata, output int lat, output logic stall0);
        @(posedge clk); #2;
        bus.req_en = 1'b1; bus.req_wen = wen; bus.req_addr = addr; bus.req_wdata = wdata;
        #1 stall0 = bus.stallreq;
        @(posedge clk); #2;
        bus.req_en = 1'b0; bus.req_wen = 4'($urandom); bus.req_addr = $urandom;
        bus.req_wdata = $urandom;
        #1;
        lat = 1;
        while (bus.stallreq === 1'b1 && lat < 64) begin
            @(posedge clk); #3;
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_valids: got %b expected 00000",
                     {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready});
        end
        vectors++;
        if (bus.req_rdata !== 32'h0 || bus.resp_err !== 1'b0 || bus.stallreq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: rdata=%h err=%b stall=%b expected 0/0/0",
                     bus.req_rdata, bus.resp_err, bus.stallreq);
        end
        rst_n = 1'b1;
        @(posedge clk); #3;
        vectors++;
        if (bus.stallreq !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_stall: got %b expected 0", bus.stallreq);
        end
    endtask

    task automatic test_read_basic();
        int lat; logic s0; int a0;
        a0 = n_ar;
        drive_txn(32'h1000_0006, 4'b0000, 32'h0, lat, s0);
        exp_rdata = mmem[32'h1000_0004];
        vectors++;
        if (s0 !== 1'b1) begin miscompares++; $display("FAIL rd_stall0: got %b expected 1", s0); end
        vectors++;
        if (lat != 3) begin miscompares++; $display("FAIL rd_latency: got %0d expected 3", lat); end
        vectors++;
        if (mon_araddr !== 32'h1000_0004) begin
            miscompares++; $display("FAIL rd_araddr: got %h expected 10000004", mon_araddr);
        end
        vectors++;
        if (bus.req_rdata !== exp_rdata) begin
            miscompares++; $display("FAIL rd_data: got %h expected %h", bus.req_rdata, exp_rdata);
        end
        vectors++;
        if (bus.resp_err !== 1'b0) begin
            miscompares++; $display("FAIL rd_err: got %b expected 0", bus.resp_err);
        end
        vectors++;
        if (n_ar - a0 != 1) begin
            miscompares++; $display("FAIL rd_ar_count: got %0d expected 1", n_ar - a0);
        end
    endtask

    task automatic test_write_aw_wait();
        int lat; logic s0; int aw0, w0, b0, awc0, wc0;
        logic [31:0] m;
        aw0 = n_aw; w0 = n_w; b0 = n_b; awc0 = aw_vcyc; wc0 = w_vcyc;
        cfg_aw_wait = 3;
        drive_txn(32'h2000_000A, 4'b0011, 32'h0000_1234, lat, s0);
        cfg_aw_wait = 0;
        m = strb_mask(4'b0011);
        mmem[32'h2000_0008] = (mmem[32'h2000_0008] & ~m) | (32'h0000_1234 & m);
        vectors++;
        if (lat != 6) begin miscompares++; $display("FAIL wr_latency: got %0d expected 6", lat); end
        vectors++;
        if (aw_vcyc - awc0 != 4) begin
            miscompares++; $display("FAIL wr_awvalid_cycles: got %0d expected 4", aw_vcyc - awc0);
        end
        vectors++;
        if (w_vcyc - wc0 != 1) begin
            miscompares++; $display("FAIL wr_wvalid_cycles: got %0d expected 1", w_vcyc - wc0);
        end
        vectors++;
        if (n_aw - aw0 != 1 || n_w - w0 != 1 || n_b - b0 != 1) begin
            miscompares++;
            $display("FAIL wr_beats: aw=%0d w=%0d b=%0d expected 1/1/1", n_aw - aw0, n_w - w0, n_b - b0);
        end
        vectors++;
        if (mon_wstrb !== 4'b0011 || mon_wdata !== 32'h0000_1234 || mon_awaddr !== 32'h2000_0008) begin
            miscompares++;
            $display("FAIL wr_payload: strb=%b data=%h addr=%h expected 0011/00001234/20000008",
                     mon_wstrb, mon_wdata, mon_awaddr);
        end
        vectors++;
        if (bus.req_rdata !== exp_rdata) begin
            miscompares++; $display("FAIL wr_keeps_rdata: got %h expected %h", bus.req_rdata, exp_rdata);
        end
        drive_txn(32'h2000_0008, 4'b0000, 32'h0, lat, s0);
        exp_rdata = mmem[32'h2000_0008];
        vectors++;
        if (bus.req_rdata !== 32'hAABB_1234) begin
            miscompares++; $display("FAIL wr_readback: got %h expected aabb1234", bus.req_rdata);
        end
    endtask

    task automatic test_read_error();
        int lat; logic s0;
        cfg_rresp = 2'b10;
        drive_txn(32'h3000_0010, 4'b0000, 32'h0, lat, s0);
        cfg_rresp = 2'b00;
        exp_rdata = mmem[32'h3000_0010];
        vectors++;
        if (bus.resp_err !== 1'b1) begin
            miscompares++; $display("FAIL rerr_flag: got %b expected 1", bus.resp_err);
        end
        vectors++;
        if (bus.req_rdata !== exp_rdata || lat != 3) begin
            miscompares++;
            $display("FAIL rerr_data: got %h lat %0d expected %h lat 3", bus.req_rdata, lat, exp_rdata);
        end
        @(posedge clk); #3;
        vectors++;
        if (bus.resp_err !== 1'b1 || bus.stallreq !== 1'b0) begin
            miscompares++;
            $display("FAIL rerr_hold_idle: err=%b stall=%b expected 1/0", bus.resp_err, bus.stallreq);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic s0; int ar0, aw0, w0;
        logic [31:0] m;
        ar0 = n_ar; aw0 = n_aw; w0 = n_w;
        drive_txn(32'h3000_0000, 4'b0000, 32'h0, lat, s0);
        exp_rdata = mmem[32'h3000_0000];
        vectors++;
        if (bus.req_rdata !== exp_rdata || lat != 3) begin
            miscompares++;
            $display("FAIL b2b_load: got %h lat %0d expected %h lat 3", bus.req_rdata, lat, exp_rdata);
        end
        // Store presented already during the load's DONE cycle and held into the next IDLE.
        bus.req_en = 1'b1; bus.req_wen = 4'b1100; bus.req_addr = 32'h3000_0004;
        bus.req_wdata = 32'h5566_0000;
        #1;
        vectors++;
        if (bus.stallreq !== 1'b0) begin
            miscompares++; $display("FAIL b2b_done_stall: got %b expected 0", bus.stallreq);
        end
        drive_txn(32'h3000_0004, 4'b1100, 32'h5566_0000, lat, s0);
        m = strb_mask(4'b1100);
        mmem[32'h3000_0004] = (mmem[32'h3000_0004] & ~m) | (32'h5566_0000 & m);
        vectors++;
        if (lat != 3 || s0 !== 1'b1) begin
            miscompares++; $display("FAIL b2b_store_lat: got %0d stall0 %b expected 3/1", lat, s0);
        end
        vectors++;
        if (n_ar - ar0 != 1 || n_aw - aw0 != 1 || n_w - w0 != 1) begin
            miscompares++;
            $display("FAIL b2b_counts: ar=%0d aw=%0d w=%0d expected 1/1/1", n_ar - ar0, n_aw - aw0, n_w - w0);
        end
    endtask

    task automatic test_reset_in_flight();
        int lat; logic s0; int ar0, r0;
        cfg_r_wait = 6;
        @(posedge clk); #2;
        bus.req_en = 1'b1; bus.req_wen = 4'b0000; bus.req_addr = 32'h3000_0004;
        @(posedge clk); #2;
        bus.req_en = 1'b0;
        @(posedge clk); #3;
        vectors++;
        if (bus.rready !== 1'b1) begin
            miscompares++; $display("FAIL rif_in_rd_data: rready=%b expected 1", bus.rready);
        end
        rst_n = 1'b0;
        #1;
        exp_rdata = 32'h0;
        vectors++;
        if (bus.arvalid !== 1'b0 || bus.rready !== 1'b0 || bus.stallreq !== 1'b0) begin
            miscompares++;
            $display("FAIL rif_async: arvalid=%b rready=%b stall=%b expected 0/0/0",
                     bus.arvalid, bus.rready, bus.stallreq);
        end
        vectors++;
        if (bus.req_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rif_regs: rdata=%h err=%b expected 0/0", bus.req_rdata, bus.resp_err);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cfg_r_wait = 0;
        ar0 = n_ar; r0 = n_r;
        drive_txn(32'h3000_0008, 4'b0000, 32'h0, lat, s0);
        exp_rdata = mmem[32'h3000_0008];
        vectors++;
        if (lat != 3 || bus.req_rdata !== exp_rdata) begin
            miscompares++;
            $display("FAIL rif_restart: lat %0d data %h expected 3/%h", lat, bus.req_rdata, exp_rdata);
        end
        vectors++;
        if (n_ar - ar0 != 1 || n_r - r0 != 1) begin
            miscompares++; $display("FAIL rif_counts: ar=%0d r=%0d expected 1/1", n_ar - ar0, n_r - r0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int lat, exp_lat, ar0, aw0, aw_w, w_w, b_w, ar_w, r_w;
            logic s0, rd, exp_err;
            logic [1:0] resp;
            logic [31:0] addr, al, wd, m;
            logic [3:0] wen;
            ar_w = $urandom_range(0, 3); r_w = $urandom_range(0, 3);
            aw_w = $urandom_range(0, 3); w_w = $urandom_range(0, 3); b_w = $urandom_range(0, 3);
            resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rd   = ($urandom_range(0, 1) == 0);
            wen  = rd ? 4'b0000 : 4'($urandom_range(1, 15));
            addr = 32'h3000_0000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            al   = addr - (addr % 4);
            wd   = $urandom;
            cfg_ar_wait = ar_w; cfg_r_wait = r_w; cfg_aw_wait = aw_w; cfg_w_wait = w_w;
            cfg_b_wait = b_w; cfg_rresp = rd ? resp : 2'b00; cfg_bresp = rd ? 2'b00 : resp;
            ar0 = n_ar; aw0 = n_aw;
            drive_txn(addr, wen, wd, lat, s0);
            exp_err = (resp != 2'b00);
            if (rd) begin
                exp_lat = 3 + ar_w + r_w;
                exp_rdata = mmem[al];
            end else begin
                exp_lat = 3 + ((aw_w > w_w) ? aw_w : w_w) + b_w;
                m = strb_mask(wen);
                mmem[al] = (mmem[al] & ~m) | (wd & m);
            end
            vectors++;
            if (lat != exp_lat) begin
                miscompares++; $display("FAIL rnd%0d_lat: got %0d expected %0d", i, lat, exp_lat);
            end
            vectors++;
            if (bus.req_rdata !== exp_rdata) begin
                miscompares++; $display("FAIL rnd%0d_rdata: got %h expected %h", i, bus.req_rdata, exp_rdata);
            end
            vectors++;
            if (bus.resp_err !== exp_err) begin
                miscompares++; $display("FAIL rnd%0d_err: got %b expected %b", i, bus.resp_err, exp_err);
            end
            vectors++;
            if (n_ar - ar0 != (rd ? 1 : 0) || n_aw - aw0 != (rd ? 0 : 1)) begin
                miscompares++;
                $display("FAIL rnd%0d_counts: ar=%0d aw=%0d read=%b", i, n_ar - ar0, n_aw - aw0, rd);
            end
            vectors++;
            if (rd ? (mon_araddr !== al)
                   : (mon_awaddr !== al || mon_wstrb !== wen || mon_wdata !== wd)) begin
                miscompares++;
                $display("FAIL rnd%0d_payload: ar=%h aw=%h strb=%b data=%h expected addr %h strb %b data %h",
                         i, mon_araddr, mon_awaddr, mon_wstrb, mon_wdata, al, wen, wd);
            end
        end
        cfg_ar_wait = 0; cfg_r_wait = 0; cfg_aw_wait = 0; cfg_w_wait = 0; cfg_b_wait = 0;
        cfg_rresp = 2'b00; cfg_bresp = 2'b00;
        vectors++;
        if (stab_viol != 0) begin
            miscompares++; $display("FAIL axi_stability: got %0d violations expected 0", stab_viol);
        end
    endtask

    initial begin
        bus.req_en = 1'b0; bus.req_wen = 4'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] v;
            v = $urandom;
            smem[32'h3000_0000 + 32'(4 * i)] = v;
            mmem[32'h3000_0000 + 32'(4 * i)] = v;
        end
        smem[32'h1000_0004] = 32'hDEAD_BEEF; mmem[32'h1000_0004] = 32'hDEAD_BEEF;
        smem[32'h2000_0008] = 32'hAABB_CCDD; mmem[32'h2000_0008] = 32'hAABB_CCDD;
        test_reset();
        test_read_basic();
        test_write_aw_wait();
        test_read_error();
        test_back_to_back();
        test_reset_in_flight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog expired");
    end
endmodule
